// File: rtl/hazard3_cdc_req_ctrl_pkg.sv
// Shared definitions for the source-side req/ack CDC controller.
package hazard3_cdc_req_ctrl_pkg;

    // Default word width for request and response words.
    localparam int W_DATA_DEFAULT = 32;

    // Controller phase encoding (4-phase handshake, source side).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

endpackage

// File: rtl/hazard3_sync_1bit.sv
// Multi-flop synchronizer for a single asynchronous level.
module hazard3_sync_1bit #(
    parameter int N_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N_STAGES-1:0] chain;

    // Shift the asynchronous level through the flop chain; stage 0 may go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[N_STAGES-2:0], d};
        end
    end

    assign q = chain[N_STAGES-1];

endmodule

// File: rtl/hazard3_cdc_req_ctrl.sv
// Source-side controller for a 4-phase req/ack clock-domain crossing.
//
// Handshake on the clk side: a word moves when src_valid && src_ready are both
// high at a rising clk edge; src_valid may be held across stalls and src_wdata
// must be stable while src_valid waits for src_ready.
//
// Foreign side: xfer_req rises with xfer_wdata already stable, the foreign
// domain raises its ack with xfer_rdata stable, xfer_req falls after the
// synchronized ack is seen, and the controller waits for the ack to fall
// before accepting the next word.
module hazard3_cdc_req_ctrl
    import hazard3_cdc_req_ctrl_pkg::*;
#(
    parameter int W_DATA        = W_DATA_DEFAULT,
    parameter int N_SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [W_DATA-1:0] src_wdata,
    output logic              rsp_valid,
    output logic [W_DATA-1:0] rsp_rdata,
    output logic              xfer_req,
    output logic [W_DATA-1:0] xfer_wdata,
    input  logic              xfer_ack_async,
    input  logic [W_DATA-1:0] xfer_rdata
);

    state_t state;
    state_t state_nxt;
    logic   ack_sync;
    logic   accept;
    logic   capture;

    // Only the synchronized ack is ever used for decisions.
    hazard3_sync_1bit #(
        .N_STAGES (N_SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (xfer_ack_async),
        .q     (ack_sync)
    );

    assign accept  = src_valid && src_ready;
    assign capture = (state == REQ_HI) && ack_sync;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack dropping early in REQ_HI is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = REQ_HI;
            REQ_HI:  if (ack_sync)  state_nxt = REQ_LO;
            REQ_LO:  if (!ack_sync) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output decode: ready only in IDLE with the ack low, forced low while reset is held.
    always_comb begin
        src_ready = 1'b0;
        case (state)
            IDLE:    src_ready = rst_n && !ack_sync;
            default: src_ready = 1'b0;
        endcase
    end

    // Request level and word come straight from flops so the foreign domain sees no glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_req   <= 1'b0;
            xfer_wdata <= '0;
        end else if (accept) begin
            xfer_req   <= 1'b1;
            xfer_wdata <= src_wdata;
        end else if (capture) begin
            xfer_req   <= 1'b0;
        end
    end

    // Response capture: rdata is stable while the ack is high, and ack_sync lags the raw ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= capture;
            if (capture) begin
                rsp_rdata <= xfer_rdata;
            end
        end
    end

endmodule

// File: tb/tb_hazard3_cdc_req_ctrl.sv
// Bench for hazard3_cdc_req_ctrl: directed latency cases plus randomized traffic
// against a foreign-domain model, with a queue-based scoreboard.
module tb_hazard3_cdc_req_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         src_valid = 1'b0;
    logic         src_ready;
    logic [W-1:0] src_wdata = '0;
    logic         rsp_valid;
    logic [W-1:0] rsp_rdata;
    logic         xfer_req;
    logic [W-1:0] xfer_wdata;
    logic         xfer_ack_async;
    logic [W-1:0] xfer_rdata;

    // Foreign side: either a combinational loopback or a delayed responder.
    logic         loop_mode = 1'b0;
    logic         fe = 1'b0;
    logic         ack_drv = 1'b0;
    logic [W-1:0] rdata_drv = '0;
    int           fdelay = 0;
    bit           rand_delay = 1'b0;

    assign xfer_ack_async = loop_mode ? xfer_req    : ack_drv;
    assign xfer_rdata     = loop_mode ? ~xfer_wdata : rdata_drv;

    int checks = 0;
    int errors = 0;
    int rsp_count = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] wq[$];
    logic [W-1:0] last_rsp = '0;

    hazard3_cdc_req_ctrl #(
        .W_DATA        (W),
        .N_SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_wdata      (src_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .xfer_req       (xfer_req),
        .xfer_wdata     (xfer_wdata),
        .xfer_ack_async (xfer_ack_async),
        .xfer_rdata     (xfer_rdata)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (timeout or missing expectation) t=%0t", name, $time);
    endtask

    // Monitor / scoreboard: compares whatever the DUT presents against the queues.
    logic         prev_req = 1'b0;
    logic         prev_rsp = 1'b0;
    logic         prev_ack = 1'b0;
    logic [W-1:0] prev_wdata = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req   = 1'b0;
            prev_rsp   = 1'b0;
            prev_ack   = 1'b0;
            prev_wdata = '0;
            last_rsp   = '0;
        end else begin
            if (xfer_req && !prev_req) begin
                if (wq.size() == 0) fail("req_rise_without_accept");
                else chk("xfer_wdata_on_req", xfer_wdata, wq.pop_front());
            end
            if (xfer_req && prev_req)
                chk("xfer_wdata_stable", xfer_wdata, prev_wdata);
            if (!xfer_req && prev_req)
                chk("rsp_valid_on_req_fall", {31'd0, rsp_valid}, 32'd1);
            if (xfer_req && prev_req && prev_ack && !loop_mode)
                chk("ack_held_while_req", {31'd0, xfer_ack_async}, 32'd1);
            if (rsp_valid) begin
                rsp_count++;
                chk("rsp_single_pulse", {31'd0, prev_rsp}, 32'd0);
                if (exp_q.size() == 0) begin
                    fail("rsp_without_request");
                end else begin
                    last_rsp = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, last_rsp);
                end
            end else begin
                chk("rsp_rdata_hold", rsp_rdata, last_rsp);
            end
            prev_req   = xfer_req;
            prev_rsp   = rsp_valid;
            prev_ack   = xfer_ack_async;
            prev_wdata = xfer_wdata;
        end
    end

    // Foreign-domain responder: ack after a delay with ~word held, release after req falls.
    initial begin
        int n;
        forever begin
            @(negedge clk);
            if (fe && rst_n && xfer_req && !ack_drv) begin
                if (rand_delay) fdelay = $urandom_range(0, 5);
                repeat (fdelay) @(negedge clk);
                rdata_drv = ~xfer_wdata;
                ack_drv   = 1'b1;
                n = 0;
                while (xfer_req && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 300) fail("foreign_req_fall");
                repeat (fdelay) @(negedge clk);
                ack_drv   = 1'b0;
                rdata_drv = $urandom;
            end
        end
    end

    // Driver: offer a word, wait for ready, record expectations, complete at the edge.
    task automatic send(input logic [W-1:0] w, input bit hold);
        int n = 0;
        @(negedge clk);
        src_valid = 1'b1;
        src_wdata = w;
        while (!src_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            fail("src_ready_wait");
            src_valid = 1'b0;
            return;
        end
        exp_q.push_back(~w);
        wq.push_back(w);
        @(posedge clk);
        #1;
        if (!hold) src_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !src_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail("drain");
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        wq.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [W-1:0] w;
    int           b2b_base;

    initial begin
        // Reset state, first acceptance right after release
        src_valid = 1'b1;
        src_wdata = 32'hdeadbeef;
        repeat (3) @(negedge clk);
        chk("reset_xfer_req", {31'd0, xfer_req}, 32'd0);
        chk("reset_src_ready", {31'd0, src_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_xfer_wdata", xfer_wdata, 32'd0);
        #2 rst_n = 1'b1;
        #1 chk("ready_after_reset", {31'd0, src_ready}, 32'd1);
        exp_q.push_back(~32'hdeadbeef);
        wq.push_back(32'hdeadbeef);
        @(posedge clk);
        #1 src_valid = 1'b0;
        @(negedge clk);
        chk("first_xfer_req", {31'd0, xfer_req}, 32'd1);
        chk("first_xfer_wdata", xfer_wdata, 32'hdeadbeef);
        fdelay = 1;
        fe = 1'b1;
        drain();
        fe = 1'b0;

        // Loopback latency: rsp at +4, ready back at +7
        loop_mode = 1'b1;
        @(negedge clk);
        src_valid = 1'b1;
        src_wdata = 32'h12345678;
        chk("loop_ready", {31'd0, src_ready}, 32'd1);
        exp_q.push_back(~32'h12345678);
        wq.push_back(32'h12345678);
        @(posedge clk);
        #1 src_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 3) chk("loop_rsp_early", {31'd0, rsp_valid}, 32'd0);
            if (k == 4) begin
                chk("loop_rsp_at4", {31'd0, rsp_valid}, 32'd1);
                chk("loop_rdata_at4", rsp_rdata, 32'hedcba987);
            end
            if (k == 5) chk("loop_rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
            if (k == 6) chk("loop_ready_at6", {31'd0, src_ready}, 32'd0);
            if (k == 7) chk("loop_ready_at7", {31'd0, src_ready}, 32'd1);
        end

        // Back-to-back under loopback
        b2b_base = rsp_count;
        send(32'd1, 1'b1);
        send(32'd2, 1'b1);
        send(32'd3, 1'b0);
        drain();
        chk("b2b_rsp_count", b2b_base + 3, rsp_count);

        // Reset while in REQ_HI
        send(32'hcafef00d, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_reset_req_hi", {31'd0, xfer_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_xfer_req", {31'd0, xfer_req}, 32'd0);
        chk("midrst_src_ready", {31'd0, src_ready}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        exp_q.delete();
        wq.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        send(32'h0badc0de, 1'b0);
        drain();

        // Stale ack held high through reset blocks acceptance
        loop_mode = 1'b0;
        ack_drv   = 1'b1;
        apply_reset();
        repeat (3) @(negedge clk);
        src_valid = 1'b1;
        src_wdata = 32'h55aa55aa;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stale_ack_ready", {31'd0, src_ready}, 32'd0);
            chk("stale_ack_req", {31'd0, xfer_req}, 32'd0);
        end
        src_valid = 1'b0;
        ack_drv   = 1'b0;
        @(negedge clk);
        chk("ack_fall_ready_1", {31'd0, src_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("ack_fall_ready_3", {31'd0, src_ready}, 32'd1);

        // Foreign side with a 5-cycle ack delay
        fe     = 1'b1;
        fdelay = 5;
        send(32'h55aa55aa, 1'b0);
        drain();
        send(32'h0f0f1234, 1'b0);
        drain();

        // Randomized traffic with random foreign delays and gaps
        rand_delay = 1'b1;
        for (int i = 0; i < 30; i++) begin
            w = $urandom;
            send(w, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        chk("final_exp_q_empty", exp_q.size(), 32'd0);
        chk("final_wq_empty", wq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        fail("global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule
